// File: rtl/qif_pkg.sv
// Shared constants and state type for the QIF neuron spike monitor.
package qif_pkg;

    localparam int unsigned V_MEM_W = 8;

    localparam logic signed [V_MEM_W-1:0] SPIKE_THRESH = 8'sd50;
    localparam logic signed [V_MEM_W-1:0] V_RESET      = -8'sd20;
    localparam logic signed [V_MEM_W-1:0] V_PREV_RST   = 8'sh80;

    typedef enum logic {
        ARMED,
        REFRACT
    } qif_state_e;

endpackage

// File: rtl/qif_window_timer.sv
// Rate-window timer: counts enabled cycles 0..WINDOW_CYCLES-1 and strobes the last one.
module qif_window_timer #(
    parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic win_end
);

    localparam logic [23:0] LAST_CYCLE = WINDOW_CYCLES - 24'd1;

    logic [23:0] win_ctr;

    assign win_end = ena && (win_ctr == LAST_CYCLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_ctr <= '0;
        end else if (ena) begin
            win_ctr <= (win_ctr == LAST_CYCLE) ? '0 : win_ctr + 24'd1;
        end
    end

endmodule

// File: rtl/qif_spike_monitor.sv
// Threshold-crossing spike detector with refractory period, free-running spike
// count and per-window spike rate for a QIF neuron membrane potential.
module qif_spike_monitor
    import qif_pkg::*;
#(
    parameter logic [23:0] WINDOW_CYCLES  = 24'd10_000_000,
    parameter int unsigned REFRACT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [V_MEM_W-1:0]  v_mem,
    input  logic [V_MEM_W-1:0]  thresh,
    output logic                spike,
    output logic [7:0]          spike_total,
    output logic [7:0]          rate,
    output logic                rate_valid,
    output logic                rate_sat
);

    localparam logic [3:0] REFR_LOAD = 4'(REFRACT_CYCLES - 1);

    logic signed [V_MEM_W-1:0] v_prev;
    qif_state_e                state;
    logic [3:0]                refr_cnt;
    logic [7:0]                win_cnt;
    logic                      win_sat;
    logic                      win_end;
    logic                      crossing;
    logic [7:0]                win_cnt_next;
    logic                      win_sat_next;

    qif_window_timer #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_window_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .win_end (win_end)
    );

    // The closing window's rate must include a spike seen on its final cycle.
    always_comb begin
        crossing = ena && (state == ARMED)
                   && (v_prev < $signed(thresh))
                   && ($signed(v_mem) >= $signed(thresh));
        win_cnt_next = win_cnt;
        win_sat_next = win_sat;
        if (crossing) begin
            if (win_cnt == 8'hFF) begin
                win_sat_next = 1'b1;
            end else begin
                win_cnt_next = win_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_prev      <= V_PREV_RST;
            state       <= ARMED;
            refr_cnt    <= '0;
            spike       <= 1'b0;
            spike_total <= '0;
            win_cnt     <= '0;
            win_sat     <= 1'b0;
            rate        <= '0;
            rate_sat    <= 1'b0;
            rate_valid  <= 1'b0;
        end else begin
            spike      <= crossing;
            rate_valid <= win_end;
            if (ena) begin
                v_prev <= $signed(v_mem);
                case (state)
                    ARMED: begin
                        if (crossing) begin
                            state    <= REFRACT;
                            refr_cnt <= REFR_LOAD;
                        end
                    end
                    REFRACT: begin
                        if (refr_cnt == 4'd0) begin
                            state <= ARMED;
                        end else begin
                            refr_cnt <= refr_cnt - 4'd1;
                        end
                    end
                    default: state <= ARMED;
                endcase
                if (crossing) begin
                    spike_total <= spike_total + 8'd1;
                end
                if (win_end) begin
                    rate     <= win_cnt_next;
                    rate_sat <= win_sat_next;
                    win_cnt  <= '0;
                    win_sat  <= 1'b0;
                end else begin
                    win_cnt <= win_cnt_next;
                    win_sat <= win_sat_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_qif_spike_monitor.sv
// Directed and randomized bench for qif_spike_monitor against an event-level model.
module tb_qif_spike_monitor;
    import qif_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] v_mem;
    logic [7:0] thresh;

    logic       spike_a, rate_valid_a, rate_sat_a;
    logic [7:0] spike_total_a, rate_a;
    logic       spike_b, rate_valid_b, rate_sat_b;
    logic [7:0] spike_total_b, rate_b;

    int errors = 0;
    int checks = 0;

    qif_spike_monitor #(
        .WINDOW_CYCLES  (24'd16),
        .REFRACT_CYCLES (4)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .v_mem       (v_mem),
        .thresh      (thresh),
        .spike       (spike_a),
        .spike_total (spike_total_a),
        .rate        (rate_a),
        .rate_valid  (rate_valid_a),
        .rate_sat    (rate_sat_a)
    );

    qif_spike_monitor #(
        .WINDOW_CYCLES  (24'd2000),
        .REFRACT_CYCLES (1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .v_mem       (v_mem),
        .thresh      (thresh),
        .spike       (spike_b),
        .spike_total (spike_total_b),
        .rate        (rate_b),
        .rate_valid  (rate_valid_b),
        .rate_sat    (rate_sat_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Event-level reference: spikes are allowed only when more than REFRACT
    // enabled cycles have passed since the last one; windows are fixed blocks
    // of enabled-cycle indices.
    int win_len  [2] = '{16, 2000};
    int refr_len [2] = '{4, 1};
    int en_idx   [2];
    int last_spk [2];
    int total    [2];
    int wcount   [2];
    byte m_vprev [2];
    logic m_spike[2];
    logic m_rv   [2];
    logic m_sat  [2];
    int m_rate   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            en_idx[i]   = 0;
            last_spk[i] = -1000;
            total[i]    = 0;
            wcount[i]   = 0;
            m_vprev[i]  = -128;
            m_spike[i]  = 1'b0;
            m_rv[i]     = 1'b0;
            m_sat[i]    = 1'b0;
            m_rate[i]   = 0;
        end
    endtask

    task automatic model_edge();
        byte v, th;
        v  = $signed(v_mem);
        th = $signed(thresh);
        for (int i = 0; i < 2; i++) begin
            m_spike[i] = 1'b0;
            m_rv[i]    = 1'b0;
            if (ena) begin
                if ((en_idx[i] - last_spk[i] > refr_len[i]) && (m_vprev[i] < th) && (v >= th)) begin
                    m_spike[i]  = 1'b1;
                    last_spk[i] = en_idx[i];
                    total[i]++;
                    wcount[i]++;
                end
                if (en_idx[i] % win_len[i] == win_len[i] - 1) begin
                    m_rv[i]   = 1'b1;
                    m_rate[i] = (wcount[i] > 255) ? 255 : wcount[i];
                    m_sat[i]  = (wcount[i] > 255);
                    wcount[i] = 0;
                end
                m_vprev[i] = v;
                en_idx[i]++;
            end
        end
    endtask

    task automatic check_all();
        chk("a.spike",       spike_a,       m_spike[0]);
        chk("a.spike_total", spike_total_a, total[0] % 256);
        chk("a.rate",        rate_a,        m_rate[0]);
        chk("a.rate_valid",  rate_valid_a,  m_rv[0]);
        chk("a.rate_sat",    rate_sat_a,    m_sat[0]);
        chk("b.spike",       spike_b,       m_spike[1]);
        chk("b.spike_total", spike_total_b, total[1] % 256);
        chk("b.rate",        rate_b,        m_rate[1]);
        chk("b.rate_valid",  rate_valid_b,  m_rv[1]);
        chk("b.rate_sat",    rate_sat_b,    m_sat[1]);
    endtask

    task automatic step(input logic [7:0] v, input logic [7:0] th, input logic en);
        v_mem  = v;
        thresh = th;
        ena    = en;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset is asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.a.spike",       spike_a,       0);
        chk("rst.a.spike_total", spike_total_a, 0);
        chk("rst.a.rate",        rate_a,        0);
        chk("rst.a.rate_valid",  rate_valid_a,  0);
        chk("rst.a.rate_sat",    rate_sat_a,    0);
        chk("rst.b.spike",       spike_b,       0);
        chk("rst.b.spike_total", spike_total_b, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] th;
        int n;
        th     = SPIKE_THRESH;
        rst_n  = 1'b0;
        ena    = 1'b0;
        v_mem  = 8'd0;
        thresh = th;
        #2;
        do_reset();

        // Single crossing, second rise lands inside refractory on dut_a.
        step(8'd40, th, 1'b1);
        chk("r030.no_spike_40", spike_a, 0);
        step(8'd55, th, 1'b1);
        chk("r030.spike_55", spike_a, 1);
        step(8'd60, th, 1'b1);
        step(8'd10, th, 1'b1);
        step(8'd52, th, 1'b1);
        chk("r030.refract_52", spike_a, 0);
        chk("r030.total", spike_total_a, 1);
        repeat (6) step(8'd10, th, 1'b1);

        // Three spikes five cycles apart in a 16-cycle window.
        do_reset();
        for (int i = 0; i < 16; i++)
            step((i == 2 || i == 7 || i == 12) ? 8'd60 : 8'd0, th, 1'b1);
        chk("r031.rate_valid", rate_valid_a, 1);
        chk("r031.rate", rate_a, 3);
        chk("r031.rate_sat", rate_sat_a, 0);

        // Spike on the window-end cycle belongs to the closing window.
        for (int i = 16; i < 32; i++)
            step((i == 31) ? 8'd60 : 8'd0, th, 1'b1);
        chk("r032.rate_valid", rate_valid_a, 1);
        chk("r032.spike_at_end", spike_a, 1);
        chk("r032.rate", rate_a, 1);
        for (int i = 32; i < 48; i++)
            step(8'd0, th, 1'b1);
        chk("r032.next_rate_valid", rate_valid_a, 1);
        chk("r032.next_rate", rate_a, 0);

        // Pause with v_prev below threshold: resuming above it is a crossing.
        repeat (6) step(8'd0, th, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(8'd60, th, 1'b0);
            chk("r034a.paused_spike", spike_a, 0);
            chk("r034a.paused_rv", rate_valid_a, 0);
        end
        step(8'd60, th, 1'b1);
        chk("r034a.resume_spike", spike_a, 1);

        // Pause with v_prev above threshold: resuming above it is not a crossing.
        repeat (6) step(8'd60, th, 1'b1);
        for (int i = 0; i < 10; i++)
            step((i % 2 == 0) ? 8'd0 : 8'd60, th, 1'b0);
        step(8'd60, th, 1'b1);
        chk("r034b.resume_spike", spike_a, 0);
        repeat (4) step(8'd0, th, 1'b1);

        // Reset at window count 9, with a spike pending on the outputs.
        do_reset();
        for (int i = 0; i < 9; i++)
            step((i == 8) ? 8'd60 : 8'd0, th, 1'b1);
        chk("r035.pre_spike", spike_a, 1);
        do_reset();
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            step(8'd0, th, 1'b1);
            if (rate_valid_a) begin
                n = i;
                break;
            end
        end
        chk("r035.first_rv_latency", n, 16);
        chk("r035.rate", rate_a, 0);

        // 300 spikes in one 2000-cycle window on dut_b.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(8'd60, th, 1'b1);
            step(8'd0, th, 1'b1);
        end
        chk("r033.total_pre", spike_total_b, 44);
        n = 1501;
        for (int i = 1; i <= 1500; i++) begin
            step(8'd0, th, 1'b1);
            if (rate_valid_b) begin
                n = i;
                break;
            end
        end
        chk("r033.window_end", n, 1400);
        chk("r033.rate", rate_b, 255);
        chk("r033.rate_sat", rate_sat_b, 1);
        chk("r033.total", spike_total_b, 44);

        // Random potentials, thresholds and enable gaps.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [7:0] rv, rt;
            rv = 8'($urandom_range(0, 255));
            rt = (i % 50 < 40) ? th : 8'($urandom_range(0, 255));
            step(rv, rt, ($urandom_range(0, 7) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
